rr_arb16: RTL and testbench
===========================

Name: rr_arb16

Overview:
- 16-requester round-robin arbiter that shares one resource. It holds the current grantee as a 4-bit index.
- The one-hot grant vector is produced by the existing decode4_16 decoder: x = current index, en = busy.
- Sits between 16 client request lines and a shared slave such as a bus port or display driver. Supports an optional hold-time limit that preempts the grantee.

Parameters:
- HOLD_MAX, default 0: maximum consecutive cycles one grantee may hold the resource. 0 = unlimited; legal range 0..255.
- CW, default 8: width of the hold counter. Must satisfy 2^CW > HOLD_MAX.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset, sampled on rising edge of clk
- req  in  16  request vector; a requester keeps its bit high for as long as it uses the resource
- gnt  out  16  one-hot grant = decode4_16(cur_id, busy); all zeros when idle
- gnt_id  out  4  index of the current grantee; valid only when gnt_vld = 1
- gnt_vld  out  1  resource currently granted (= busy)
- preempt  out  1  one-cycle pulse: the current grant was ended by a HOLD_MAX timeout

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst), the only reset; no asynchronous reset path.
- Registers: busy, cur_id[3:0], ptr[3:0] (next search start), cnt[CW-1:0], preempt.
- Reset values: busy = 0, cur_id = 0, ptr = 0, cnt = 0, preempt = 0. Therefore gnt = 0, gnt_vld = 0, gnt_id = 0.
- Pick function (combinational): the first i in the order ptr, ptr+1, ..., ptr+15 (mod 16) with req[i] = 1. "Found" = |req.
- State IDLE (busy = 0):
  - If found at edge: busy <= 1, cur_id <= pick, cnt <= 0.
  - Grant latency is 1 cycle: req sampled at edge n, gnt visible from edge n onward.
- State BUSY, release (req[cur_id] = 0):
  - ptr <= cur_id+1 (wraps 15 -> 0).
  - If another request is found, search from cur_id+1 and hand off directly with no idle bubble: cur_id <= pick, cnt <= 0.
  - Otherwise busy <= 0.
- State BUSY, hold (req[cur_id] = 1, HOLD_MAX = 0 or cnt < HOLD_MAX-1): cnt <= cnt+1. cnt saturates at its maximum value when HOLD_MAX = 0.
- State BUSY, timeout (HOLD_MAX > 0, req[cur_id] = 1, cnt == HOLD_MAX-1):
  - preempt <= 1 for one cycle.
  - Re-arbitrate starting at cur_id+1. If cur_id is the sole requester, it is re-granted: cur_id unchanged, cnt <= 0, busy stays 1.
  - ptr <= cur_id+1 in all cases.
- preempt is 0 in every cycle not described above.
- A new grant takes effect in the same edge as the release or timeout. gnt never has two bits set and never glitches, because it is decoded from registers only.
- Requests that rise while busy are queued only by the requester holding its bit; there is no internal request latch.
- Simultaneous events:
  - Release and timeout in the same cycle: release wins, so preempt = 0.
  - rst with any req pattern: reset wins; the grant drops on that edge.
- Reset mid-grant: gnt = 0 from the reset edge. The first grant after reset searches from index 0.
- Fairness: each requester that keeps req high is granted within 15 other grants.

Decomposition:
- Package rr_arb_pkg:
  - constants N_REQ = 16, ID_W = 4
  - localparam for IDLE/BUSY encoding (1-bit)
  - function rr_pick(req, start) returning the 4-bit index
- Sub-module: decode4_16, instantiated once to generate gnt from cur_id and busy.
- Pick logic: double the req vector and mask it, or rotate then priority-encode. Keep it in the package function; no separate module.

Test Plan:
- Reset, single requester:
  - rst = 1 for 2 cycles with req = 16'hFFFF -> gnt = 0, gnt_vld = 0, preempt = 0.
  - Release rst with req = 16'h0010 -> after 1 edge gnt = 16'h0010, gnt_id = 4.
- Round-robin rotation: req = 16'h0111, each grantee drops its req for 1 cycle after 2 cycles of use, then re-raises -> grant order 0, 4, 8, 0, 4 with no idle cycles between grants.
- Wrap-around: grant id 15 with req = 16'h8001, then drop bit 15 -> the next edge grants id 0 (gnt = 16'h0001), and ptr = 0.
- Timeout, two requesters: HOLD_MAX = 4, req = 16'h0003 held constant -> id 0 holds exactly 4 cycles, preempt pulses once, id 1 is granted, then id 0 again after 4 more cycles.
- Timeout, sole requester: HOLD_MAX = 4, req = 16'h0004 only -> preempt pulses every 4 cycles, gnt stays 16'h0004 continuously.
- Reset mid-grant and simultaneous events:
  - Assert rst while gnt = 16'h0200 -> gnt = 0 on the same edge; the first grant afterwards with req = 16'h0201 goes to id 0.
  - Release and timeout in the same cycle -> preempt stays 0.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared constants and the rotating-priority pick function for the 16-way round-robin arbiter.
package rr_arb_pkg;

    localparam int N_REQ = 16;
    localparam int ID_W  = 4;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    // Rotate req so that 'start' lands at bit 0, then take the lowest set bit.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input logic [ID_W-1:0]  start);
        logic [N_REQ-1:0] rot;
        logic [ID_W-1:0]  idx;
        for (int i = 0; i < N_REQ; i++) begin
            rot[i] = req[start + ID_W'(i)];
        end
        idx = start;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) idx = start + ID_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/decode4_16.sv
// 4-to-16 one-hot decoder with enable; output is all zeros when disabled.
module decode4_16
    import rr_arb_pkg::*;
(
    input  logic [ID_W-1:0]  x,
    input  logic             en,
    output logic [N_REQ-1:0] y
);

    always_comb begin
        y = '0;
        if (en) y[x] = 1'b1;
    end

endmodule

// File: rtl/rr_arb16.sv
// 16-requester round-robin arbiter with an optional per-grant hold limit that preempts the grantee.
//
// state | meaning
// IDLE  | no grant; next edge grants the first requester found from ptr
// BUSY  | cur_id owns the resource; release, timeout or hold decided each edge
module rr_arb16
    import rr_arb_pkg::*;
#(
    parameter int HOLD_MAX = 0,
    parameter int CW       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_vld,
    output logic             preempt
);

    localparam bit            HOLD_EN   = (HOLD_MAX > 0);
    localparam logic [CW-1:0] HOLD_LAST = CW'((HOLD_MAX > 0) ? (HOLD_MAX - 1) : 0);

    if ((HOLD_MAX < 0) || (HOLD_MAX > 255) || ((1 << CW) <= HOLD_MAX)) begin : g_bad_param
        $error("rr_arb16: HOLD_MAX must be 0..255 and fit in CW bits");
    end

    logic [0:0]      state;
    logic [ID_W-1:0] cur_id;
    logic [ID_W-1:0] ptr;
    logic [CW-1:0]   cnt;

    logic [ID_W-1:0] next_id;
    logic [ID_W-1:0] search_start;
    logic [ID_W-1:0] pick;
    logic            found;
    logic            holding;
    logic            timeout;
    logic            busy;

    assign busy    = (state == BUSY);
    assign next_id = cur_id + 4'd1;

    // While busy the search always restarts just past the grantee, so a sole
    // requester that times out wraps all the way round and picks itself again.
    always_comb begin
        search_start = busy ? next_id : ptr;
        pick         = rr_pick(req, search_start);
        found        = |req;
        holding      = req[cur_id];
        timeout      = HOLD_EN && holding && (cnt == HOLD_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cur_id  <= '0;
            ptr     <= '0;
            cnt     <= '0;
            preempt <= 1'b0;
        end else begin
            preempt <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        state  <= BUSY;
                        cur_id <= pick;
                        cnt    <= '0;
                    end
                end
                BUSY: begin
                    if (!holding) begin
                        ptr <= next_id;
                        if (found) begin
                            cur_id <= pick;
                            cnt    <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (timeout) begin
                        preempt <= 1'b1;
                        ptr     <= next_id;
                        cur_id  <= pick;
                        cnt     <= '0;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    decode4_16 u_dec (
        .x  (cur_id),
        .en (busy),
        .y  (gnt)
    );

    assign gnt_id  = cur_id;
    assign gnt_vld = busy;

endmodule

// File: tb/tb_rr_arb16.sv
// Directed bench for rr_arb16: one instance unlimited hold, one with a hold limit of 4.
module tb_rr_arb16;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req0, req4;
    logic [15:0] gnt0, gnt4;
    logic [3:0]  id0, id4;
    logic        vld0, vld4;
    logic        pre0, pre4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rr_arb16 #(.HOLD_MAX(0), .CW(8)) dut0 (
        .clk(clk), .rst(rst), .req(req0),
        .gnt(gnt0), .gnt_id(id0), .gnt_vld(vld0), .preempt(pre0)
    );

    rr_arb16 #(.HOLD_MAX(4), .CW(8)) dut4 (
        .clk(clk), .rst(rst), .req(req4),
        .gnt(gnt4), .gnt_id(id4), .gnt_vld(vld4), .preempt(pre4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_ids [5] = '{0, 4, 8, 0, 4};
        logic [15:0] base;

        // reset with every request high
        rst  = 1'b1;
        req0 = 16'hFFFF;
        req4 = 16'h0000;
        step();
        step();
        chk("rst_gnt",     32'(gnt0), 32'h0000);
        chk("rst_vld",     32'(vld0), 32'h0);
        chk("rst_preempt", 32'(pre0), 32'h0);
        chk("rst_id",      32'(id0),  32'h0);
        chk("rst_gnt4",    32'(gnt4), 32'h0000);

        // single requester
        rst  = 1'b0;
        req0 = 16'h0010;
        step();
        chk("single_gnt", 32'(gnt0), 32'h0010);
        chk("single_id",  32'(id0),  32'h4);
        chk("single_vld", 32'(vld0), 32'h1);

        // round-robin rotation from a fresh reset
        rst  = 1'b1;
        req0 = 16'h0000;
        step();
        chk("rr_rst_gnt", 32'(gnt0), 32'h0000);
        rst  = 1'b0;
        base = 16'h0111;
        req0 = base;
        step();
        for (int k = 0; k < 5; k++) begin
            req0 = base;
            chk($sformatf("rr_id_%0d_a", k), 32'(id0),  32'(exp_ids[k]));
            chk($sformatf("rr_vld_%0d",  k), 32'(vld0), 32'h1);
            step();
            chk($sformatf("rr_id_%0d_b", k), 32'(id0),  32'(exp_ids[k]));
            chk($sformatf("rr_gnt_%0d",  k), 32'(gnt0), 32'(16'h0001 << exp_ids[k]));
            req0 = base & ~(16'h0001 << exp_ids[k]);
            step();
        end
        chk("rr_after_id", 32'(id0), 32'h8);

        // wrap-around 15 -> 0
        req0 = 16'h8000;
        step();
        chk("wrap_id15", 32'(id0), 32'hF);
        req0 = 16'h8001;
        step();
        chk("wrap_hold15", 32'(id0), 32'hF);
        req0 = 16'h0001;
        step();
        chk("wrap_gnt", 32'(gnt0),     32'h0001);
        chk("wrap_ptr", 32'(dut0.ptr), 32'h0);

        // reset mid-grant
        req0 = 16'h0200;
        step();
        chk("mid_gnt", 32'(gnt0), 32'h0200);
        rst = 1'b1;
        step();
        chk("mid_rst_gnt", 32'(gnt0), 32'h0000);
        chk("mid_rst_vld", 32'(vld0), 32'h0);
        rst  = 1'b0;
        req0 = 16'h0201;
        step();
        chk("post_rst_id", 32'(id0), 32'h0);
        req0 = 16'h0000;
        step();
        chk("idle_vld", 32'(vld0), 32'h0);
        chk("idle_gnt", 32'(gnt0), 32'h0000);

        // timeout with two requesters, hold limit 4
        req4 = 16'h0003;
        step();
        chk("to_first_id", 32'(id4), 32'h0);
        chk("to_first_pre", 32'(pre4), 32'h0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("to_hold0_id_%0d", c),  32'(id4),  32'h0);
            chk($sformatf("to_hold0_pre_%0d", c), 32'(pre4), 32'h0);
        end
        step();
        chk("to_switch_id",  32'(id4),  32'h1);
        chk("to_switch_pre", 32'(pre4), 32'h1);
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("to_hold1_id_%0d", c),  32'(id4),  32'h1);
            chk($sformatf("to_hold1_pre_%0d", c), 32'(pre4), 32'h0);
        end
        step();
        chk("to_back_id",  32'(id4),  32'h0);
        chk("to_back_pre", 32'(pre4), 32'h1);

        // sole requester re-granted with a preempt pulse every 4 cycles
        req4 = 16'h0004;
        step();
        chk("sole_gnt", 32'(gnt4), 32'h0004);
        chk("sole_pre", 32'(pre4), 32'h0);
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++) begin
                step();
                chk($sformatf("sole_gnt_%0d_%0d", r, c), 32'(gnt4), 32'h0004);
                chk($sformatf("sole_pre_%0d_%0d", r, c), 32'(pre4), (c == 3) ? 32'h1 : 32'h0);
            end
        end

        // release on the cycle that would have timed out
        for (int c = 0; c < 3; c++) step();
        chk("rel_to_pre_before", 32'(pre4), 32'h0);
        req4 = 16'h0008;
        step();
        chk("rel_to_gnt", 32'(gnt4), 32'h0008);
        chk("rel_to_pre", 32'(pre4), 32'h0);
        step();
        chk("rel_to_pre_after", 32'(pre4), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
